expr_recognizer: RTL and testbench

EXPR_RECOGNIZER -- requirements
Module: expr_recognizer

---
 rtl/expr_pkg.sv | 25 ++
 rtl/expr_char_class.sv | 39 +++
 rtl/expr_recognizer.sv | 155 +++++++++++++++
 tb/tb_expr_recognizer.sv | 110 +++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared definitions for the expression recognizer.
//   state_t  : FSM state encoding (S_CLOSE exists only with parenthesis support)
//   cclass_t : character class produced by expr_char_class
//   ASCII_*  : character codes for digits, operators and parentheses
// Optional feature macro: EXPR_RECOGNIZER_PAREN_EN (enables parenthesis handling).
package expr_pkg;

`ifdef EXPR_RECOGNIZER_PAREN_EN
    typedef enum logic [2:0] {S_START, S_NUM, S_OP, S_CLOSE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_START, S_NUM, S_OP, S_ERR} state_t;
`endif

    typedef enum logic [2:0] {C_DIG, C_OP, C_LP, C_RP, C_BAD} cclass_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_LP    = 8'h28;
    localparam logic [7:0] ASCII_RP    = 8'h29;

endpackage

// File: rtl/expr_char_class.sv
// Combinational character classifier.
//   Parameter EXT_OPS : 1 adds '-' and '/' to the operator set.
//   in  [7:0]         : ASCII character
//   cls               : DIG, OP, LP, RP or BAD
// Optional feature macro: EXPR_RECOGNIZER_PAREN_EN. Without it '(' and ')'
// classify as BAD.
module expr_char_class
    import expr_pkg::*;
#(
    parameter bit EXT_OPS = 1'b0
) (
    input  logic [7:0] in,
    output cclass_t    cls
);

`ifdef EXPR_RECOGNIZER_PAREN_EN
    localparam cclass_t LP_CLASS = C_LP;
    localparam cclass_t RP_CLASS = C_RP;
`else
    localparam cclass_t LP_CLASS = C_BAD;
    localparam cclass_t RP_CLASS = C_BAD;
`endif

    always_comb begin
        cls = C_BAD;
        if (in >= ASCII_0 && in <= ASCII_9) begin
            cls = C_DIG;
        end else if (in == ASCII_PLUS || in == ASCII_STAR) begin
            cls = C_OP;
        end else if (EXT_OPS && (in == ASCII_MINUS || in == ASCII_SLASH)) begin
            cls = C_OP;
        end else if (in == ASCII_LP) begin
            cls = LP_CLASS;
        end else if (in == ASCII_RP) begin
            cls = RP_CLASS;
        end
    end

endmodule

// File: rtl/expr_recognizer.sv
// Streaming recognizer for arithmetic expressions of the form
//   num (op num)* with optional parenthesised sub-expressions.
//   clk      : clock
//   clr      : synchronous active-high reset
//   in_valid : qualifies in; idle cycles hold all state
//   in [7:0] : ASCII character
//   out      : accepted prefix is a complete valid expression (registered)
//   err      : sticky syntax error (registered)
//   depth    : current open-parenthesis count
// Optional feature macro: EXPR_RECOGNIZER_PAREN_EN. Without it parentheses are
// syntax errors, S_CLOSE and the depth counter do not exist, depth reads 0.
module expr_recognizer
    import expr_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int MAX_DEPTH  = 3,
    parameter bit EXT_OPS    = 1'b0
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           in_valid,
    input  logic [7:0]                     in,
    output logic                           out,
    output logic                           err,
    output logic [$clog2(MAX_DEPTH+1)-1:0] depth
);

    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

    cclass_t       w_cls;
    state_t        r_state, w_next_state;
    logic [CW-1:0] r_cnt, w_next_cnt;
    logic          r_out, r_err;
    logic          w_next_out;

    expr_char_class #(.EXT_OPS(EXT_OPS)) u_class (
        .in  (in),
        .cls (w_cls)
    );

`ifdef EXPR_RECOGNIZER_PAREN_EN
    localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_DEPTH);
    logic [DW-1:0] r_depth, w_next_depth;
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
`ifdef EXPR_RECOGNIZER_PAREN_EN
        w_next_depth = r_depth;
`endif
        case (r_state)
            S_START, S_OP: begin
                if (w_cls == C_DIG) begin
                    w_next_state = S_NUM;
                    w_next_cnt   = CW'(1);
`ifdef EXPR_RECOGNIZER_PAREN_EN
                end else if (w_cls == C_LP) begin
                    // Overflowing the nesting limit errors without touching depth.
                    if (r_depth == DEPTH_MAX) begin
                        w_next_state = S_ERR;
                    end else begin
                        w_next_state = S_START;
                        w_next_depth = r_depth + DW'(1);
                    end
`endif
                end else begin
                    w_next_state = S_ERR;
                end
            end
            S_NUM: begin
                if (w_cls == C_DIG) begin
                    // Counter saturates: the overflowing digit errors, count stays.
                    if (r_cnt == CNT_MAX) begin
                        w_next_state = S_ERR;
                    end else begin
                        w_next_cnt = r_cnt + CW'(1);
                    end
                end else if (w_cls == C_OP) begin
                    w_next_state = S_OP;
`ifdef EXPR_RECOGNIZER_PAREN_EN
                end else if (w_cls == C_RP) begin
                    if (r_depth == '0) begin
                        w_next_state = S_ERR;
                    end else begin
                        w_next_state = S_CLOSE;
                        w_next_depth = r_depth - DW'(1);
                    end
`endif
                end else begin
                    w_next_state = S_ERR;
                end
            end
`ifdef EXPR_RECOGNIZER_PAREN_EN
            S_CLOSE: begin
                if (w_cls == C_OP) begin
                    w_next_state = S_OP;
                end else if (w_cls == C_RP) begin
                    if (r_depth == '0) begin
                        w_next_state = S_ERR;
                    end else begin
                        w_next_state = S_CLOSE;
                        w_next_depth = r_depth - DW'(1);
                    end
                end else begin
                    w_next_state = S_ERR;
                end
            end
`endif
            default: begin
                // S_ERR absorbs everything until clr.
                w_next_state = r_state;
            end
        endcase

        // out is computed from the next state so it registers alongside it.
`ifdef EXPR_RECOGNIZER_PAREN_EN
        w_next_out = ((w_next_state == S_NUM) || (w_next_state == S_CLOSE)) &&
                     (w_next_depth == '0);
`else
        w_next_out = (w_next_state == S_NUM);
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_err   <= 1'b0;
`ifdef EXPR_RECOGNIZER_PAREN_EN
            r_depth <= '0;
`endif
        end else if (in_valid) begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_out   <= w_next_out;
            r_err   <= (w_next_state == S_ERR);
`ifdef EXPR_RECOGNIZER_PAREN_EN
            r_depth <= w_next_depth;
`endif
        end
    end

    assign out = r_out;
    assign err = r_err;
`ifdef EXPR_RECOGNIZER_PAREN_EN
    assign depth = r_depth;
`else
    assign depth = '0;
`endif

endmodule

// File: tb/tb_expr_recognizer.sv
// Scoreboard bench for expr_recognizer: two instances (EXT_OPS=0 and
// EXT_OPS=1) share one stimulus stream. Stimulus strings use '_' for an idle
// cycle (in_valid=0) and '!' for clr asserted together with a valid digit.
module tb_expr_recognizer;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in = 8'h00;
    logic       out_a, err_a, out_b, err_b;
    logic [1:0] depth_a, depth_b;

    always #5 clk = ~clk;

    expr_recognizer #(.MAX_DIGITS(4), .MAX_DEPTH(3), .EXT_OPS(1'b0)) dut_a (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_a), .err(err_a), .depth(depth_a)
    );

    expr_recognizer #(.MAX_DIGITS(4), .MAX_DEPTH(3), .EXT_OPS(1'b1)) dut_b (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(out_b), .err(err_b), .depth(depth_b)
    );

    typedef struct {
        string tag;
        logic  oa, ea, ob, eb;
        int    dp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: one expectation per clock edge, sampled 1 time unit after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, " out_a"}, int'(out_a), int'(e.oa));
            chk({e.tag, " err_a"}, int'(err_a), int'(e.ea));
            chk({e.tag, " out_b"}, int'(out_b), int'(e.ob));
            chk({e.tag, " err_b"}, int'(err_b), int'(e.eb));
            chk({e.tag, " depth_a"}, int'(depth_a), e.dp);
            chk({e.tag, " depth_b"}, int'(depth_b), e.dp);
        end
    end

    // Drive a string; expectation strings give per-character values.
    // Empty ob/eb mean "same as dut_a"; empty dp means depth 0 throughout.
    task automatic run(input string name, input string s,
                       input string oa, input string ea,
                       input string ob, input string eb, input string dp);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            clr      = (s[i] == "!");
            in_valid = (s[i] != "_");
            in       = (s[i] == "!") ? 8'h35 : ((s[i] == "_") ? 8'h28 : s[i]);
            e.tag = $sformatf("%s[%0d]", name, i);
            e.oa  = (oa[i] == "1");
            e.ea  = (ea[i] == "1");
            e.ob  = (ob.len() == 0) ? e.oa : (ob[i] == "1");
            e.eb  = (eb.len() == 0) ? e.ea : (eb[i] == "1");
            e.dp  = (dp.len() == 0) ? 0 : int'(dp[i]) - 48;
            q.push_back(e);
        end
    endtask

    initial begin
        run("reset",   "!",        "0",        "0",        "",     "",     "");
        run("sum",     "12+3!",    "11010",    "00000",    "",     "",     "");
        run("digits",  "12345+7!", "11110000", "00001110", "",     "",     "");
        run("minus",   "3-2!",     "1000",     "0110",     "1010", "0000", "");
        run("idle",    "7___+!",   "111100",   "000000",   "",     "",     "");
        run("zeros",   "0007*1!",  "1111010",  "0000000",  "",     "",     "");
        run("badch",   "5a1!",     "1000",     "0110",     "",     "",     "");
`ifdef EXPR_RECOGNIZER_PAREN_EN
        run("nest",    "(4*(5+6))!", "0000000010", "0000000000", "", "", "1112222100");
        run("deep",    "((((!",    "00000",    "00010",    "",     "",     "12330");
        run("under",   ")!",       "00",       "10",       "",     "",     "00");
        run("midclr",  "(1!",      "000",      "000",      "",     "",     "110");
        run("close",   "(1)+2!",   "001010",   "000000",   "",     "",     "110000");
        run("rpdig",   "(1)3!",    "00100",    "00010",    "",     "",     "11000");
`else
        run("noparen", "(1!",      "000",      "110",      "",     "",     "");
        run("norp",    "1)!",      "100",      "010",      "",     "",     "");
`endif
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
